// File: rtl/top_pkg.sv
// Shared definitions for the radix-4 SRT single-precision divider.
//   state_e   : controller states (IDLE -> ITER -> DONE)
//   qdigit_t  : signed quotient digit in {-2..2}
//   fcls_t    : operand class flags (zero / inf / nan)
//   classify(): derives the class flags from a biased exponent and fraction
package top_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned BIAS     = 127;
    localparam int unsigned NUM_ITER = 13;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    typedef logic signed [2:0] qdigit_t;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } fcls_t;

    // Denormals (exp == 0) are flushed and treated as zero.
    function automatic fcls_t classify(input logic [7:0] e, input logic [22:0] f);
        fcls_t c;
        c.zero = (e == 8'h00);
        c.inf  = (e == 8'hFF) && (f == '0);
        c.nan  = (e == 8'hFF) && (f != '0);
        return c;
    endfunction

endpackage

// File: rtl/srt_qsel.sv
// Radix-4 SRT quotient-digit selection (minimally redundant, a = 2).
//   rem_msb_i  : 4w truncated to 7 bits, two's complement, LSB weight 1/8
//   div_bits_i : the 3 divisor fraction bits following the hidden 1
//   q_digit_o  : selected digit in {-2,-1,0,1,2}
module srt_qsel
    import top_pkg::*;
(
    input  logic [6:0] rem_msb_i,
    input  logic [2:0] div_bits_i,
    output qdigit_t    q_digit_o
);

    logic signed [6:0] est;
    logic signed [6:0] m2, m1, m0, mn1;

    // Thresholds in units of 1/8. Each lies inside the overlap of adjacent
    // digit intervals for the whole divisor slice, widened by the 1/8
    // truncation error of the (non-redundant) remainder estimate.
    always_comb begin
        m2  = 7'sd12;
        m1  = 7'sd3;
        m0  = -7'sd5;
        mn1 = -7'sd13;
        case (div_bits_i)
            3'd0: begin m2 = 7'sd12; m1 = 7'sd3; m0 = -7'sd5;  mn1 = -7'sd13; end
            3'd1: begin m2 = 7'sd14; m1 = 7'sd4; m0 = -7'sd6;  mn1 = -7'sd15; end
            3'd2: begin m2 = 7'sd15; m1 = 7'sd4; m0 = -7'sd6;  mn1 = -7'sd16; end
            3'd3: begin m2 = 7'sd16; m1 = 7'sd4; m0 = -7'sd7;  mn1 = -7'sd18; end
            3'd4: begin m2 = 7'sd18; m1 = 7'sd5; m0 = -7'sd8;  mn1 = -7'sd20; end
            3'd5: begin m2 = 7'sd19; m1 = 7'sd5; m0 = -7'sd8;  mn1 = -7'sd21; end
            3'd6: begin m2 = 7'sd20; m1 = 7'sd5; m0 = -7'sd9;  mn1 = -7'sd23; end
            default: begin m2 = 7'sd22; m1 = 7'sd6; m0 = -7'sd10; mn1 = -7'sd25; end
        endcase
    end

    always_comb begin
        est = signed'(rem_msb_i);
        if (est >= m2)
            q_digit_o = 3'sd2;
        else if (est >= m1)
            q_digit_o = 3'sd1;
        else if (est >= m0)
            q_digit_o = 3'sd0;
        else if (est >= mn1)
            q_digit_o = -3'sd1;
        else
            q_digit_o = -3'sd2;
    end

endmodule

// File: rtl/top.sv
// IEEE-754 single-precision divider, q = R / D, radix-4 SRT, 13 iterations.
//   clk, resetn          : rising-edge clock, asynchronous active-low reset
//   start                : level request, sampled only in IDLE
//   Rsign/Rexp/Rmantissa : dividend fields
//   Dsign/Dexp/Dmantissa : divisor fields
//   q                    : registered result {sign, exp, frac}, truncated
// Latency: q updates 14 edges after the sampling edge (load + 13 + done).
module top
    import top_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        Rsign,
    input  logic [7:0]  Rexp,
    input  logic [22:0] Rmantissa,
    input  logic        Dsign,
    input  logic [7:0]  Dexp,
    input  logic [22:0] Dmantissa,
    output logic [31:0] q
);

    localparam logic [3:0] LAST_CNT = 4'(NUM_ITER - 1);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    // Partial remainder, LSB weight 2^-25; loaded with Rm/4 so |w| <= 2/3 D.
    logic signed [27:0] w_q, w_d;
    // Accumulated quotient, LSB weight 2^-24 relative to Rm/Dm.
    logic signed [26:0] qacc_q, qacc_d;
    logic [23:0]        dman_q, dman_d;
    logic               sign_q, sign_d;
    logic [7:0]         rexp_q, rexp_d, dexp_q, dexp_d;
    fcls_t              rcls_q, rcls_d, dcls_q, dcls_d;
    logic [31:0]        q_q, q_d;

    logic signed [29:0] w_sh, d_mul, w_next;
    qdigit_t            digit;
    logic [24:0]        qfin;
    logic               norm;
    logic [22:0]        frac;
    logic signed [9:0]  exp_res;
    logic [31:0]        result;

    assign w_sh = {w_q, 2'b00};

    srt_qsel u_qsel (
        .rem_msb_i (w_sh[28:22]),
        .div_bits_i(dman_q[22:20]),
        .q_digit_o (digit)
    );

    // Iteration datapath: w <- 4w - q_j*D, Q <- 4Q + q_j.
    always_comb begin
        case (digit)
            3'sd2:   d_mul = signed'({3'b000, dman_q, 3'b000});
            3'sd1:   d_mul = signed'({4'b0000, dman_q, 2'b00});
            -3'sd1:  d_mul = -signed'({4'b0000, dman_q, 2'b00});
            -3'sd2:  d_mul = -signed'({3'b000, dman_q, 3'b000});
            default: d_mul = '0;
        endcase
        w_next = w_sh - d_mul;
    end

    // Finalisation: negative remainder borrows one ulp, then normalise to [1,2).
    always_comb begin
        qfin    = 25'(qacc_q - signed'({26'd0, w_q[27]}));
        norm    = qfin[24];
        frac    = norm ? qfin[23:1] : qfin[22:0];
        exp_res = signed'({2'b00, rexp_q}) - signed'({2'b00, dexp_q})
                  + signed'(10'(BIAS)) - (norm ? 10'sd0 : 10'sd1);

        if (rcls_q.nan || dcls_q.nan || (rcls_q.zero && dcls_q.zero) ||
            (rcls_q.inf && dcls_q.inf))
            result = QNAN;
        else if (rcls_q.inf || dcls_q.zero)
            result = {sign_q, 8'hFF, 23'd0};
        else if (rcls_q.zero || dcls_q.inf)
            result = {sign_q, 31'd0};
        else if (exp_res >= 10'sd255)
            result = {sign_q, 8'hFF, 23'd0};
        else if (exp_res <= 10'sd0)
            result = {sign_q, 31'd0};
        else
            result = {sign_q, exp_res[7:0], frac};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        qacc_d  = qacc_q;
        dman_d  = dman_q;
        sign_d  = sign_q;
        rexp_d  = rexp_q;
        dexp_d  = dexp_q;
        rcls_d  = rcls_q;
        dcls_d  = dcls_q;
        q_d     = q_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    w_d     = signed'({4'b0000, 1'b1, Rmantissa});
                    qacc_d  = '0;
                    cnt_d   = '0;
                    dman_d  = {1'b1, Dmantissa};
                    sign_d  = Rsign ^ Dsign;
                    rexp_d  = Rexp;
                    dexp_d  = Dexp;
                    rcls_d  = classify(Rexp, Rmantissa);
                    dcls_d  = classify(Dexp, Dmantissa);
                    state_d = ITER;
                end
            end
            ITER: begin
                w_d    = w_next[27:0];
                qacc_d = (qacc_q <<< 2) + signed'({{24{digit[2]}}, digit});
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT)
                    state_d = DONE;
            end
            DONE: begin
                q_d     = result;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
            qacc_q  <= '0;
            dman_q  <= '0;
            sign_q  <= 1'b0;
            rexp_q  <= '0;
            dexp_q  <= '0;
            rcls_q  <= '0;
            dcls_q  <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            qacc_q  <= qacc_d;
            dman_q  <= dman_d;
            sign_q  <= sign_d;
            rexp_q  <= rexp_d;
            dexp_q  <= dexp_d;
            rcls_q  <= rcls_d;
            dcls_q  <= dcls_d;
            q_q     <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_top.sv
// Directed self-checking bench for the SRT single-precision divider.
module tb_top;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        Rsign, Dsign;
    logic [7:0]  Rexp, Dexp;
    logic [22:0] Rmantissa, Dmantissa;
    logic [31:0] q;

    int unsigned n_run  = 0;
    int unsigned n_fail = 0;
    logic [31:0] last_q = '0;

    always #5 clk = ~clk;

    top dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .Rsign    (Rsign),
        .Rexp     (Rexp),
        .Rmantissa(Rmantissa),
        .Dsign    (Dsign),
        .Dexp     (Dexp),
        .Dmantissa(Dmantissa),
        .q        (q)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    task automatic set_ops(input logic [31:0] r, input logic [31:0] d);
        {Rsign, Rexp, Rmantissa} = r;
        {Dsign, Dexp, Dmantissa} = d;
    endtask

    // One operation with mid-operation operand and start disturbances.
    task automatic run_op(input string tag, input logic [31:0] r, input logic [31:0] d,
                          input logic [31:0] want);
        set_ops(r, d);
        start = 1'b1;
        @(posedge clk);                 // sampling edge S
        #1 start = 1'b0;
        set_ops(~r, ~d);
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        repeat (4) @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);      // S+13
        #1 check_eq({tag, "_hold"}, q, last_q);
        @(posedge clk);                 // S+14
        #1 check_eq(tag, q, want);
        last_q = want;
    endtask

    initial begin
        resetn = 1'b1;
        start  = 1'b0;
        set_ops('0, '0);
        #2 resetn = 1'b0;
        #1 check_eq("reset_q", q, 32'h0000_0000);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        last_q = '0;
        @(negedge clk);

        // Back-to-back with start held: 1.8125/1.875 then 6/2.
        set_ops(32'h01E8_0000, 32'h01F0_0000);
        start = 1'b1;
        @(posedge clk);                 // S
        #1 set_ops(32'h40C0_0000, 32'h4000_0000);
        repeat (13) @(posedge clk);
        #1 check_eq("b2b_hold0", q, 32'h0000_0000);
        @(posedge clk);                 // S+14
        #1 check_eq("b2b_first", q, 32'h3F77_7777);
        @(posedge clk);                 // S+15 samples 6/2
        #1 start = 1'b0;
        set_ops(32'h1234_5678, 32'h0ABC_DEF0);
        repeat (13) @(posedge clk);     // S+28
        #1 check_eq("b2b_hold1", q, 32'h3F77_7777);
        @(posedge clk);                 // S+29
        #1 check_eq("b2b_second", q, 32'h4040_0000);
        last_q = 32'h4040_0000;
        repeat (2) @(posedge clk);
        #1;

        run_op("div_6_2",      32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
        run_op("div_m6_2",     32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000);
        run_op("div_1_3",      32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA);
        run_op("div_1_1",      32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        run_op("div_1_0",      32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000);
        run_op("div_0_0",      32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000);
        run_op("div_0_5",      32'h0000_0000, 32'h40A0_0000, 32'h0000_0000);
        run_op("div_ovf",      32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000);
        run_op("div_unf",      32'h0080_0000, 32'h7F00_0000, 32'h0000_0000);
        run_op("div_nan",      32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000);
        run_op("div_inf_inf",  32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
        run_op("div_inf_2",    32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000);
        run_op("div_m1_inf",   32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000);
        run_op("div_1_m0",     32'h3F80_0000, 32'h8000_0000, 32'hFF80_0000);
        run_op("div_denorm",   32'h0040_0000, 32'h3F80_0000, 32'h0000_0000);
        run_op("div_3_7",      32'h4040_0000, 32'h40E0_0000, 32'h3EDB_6DB6);

        // Reset during iteration 6 aborts the operation.
        set_ops(32'h40C0_0000, 32'h4000_0000);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1 resetn = 1'b0;
        #1 check_eq("rst_async_q", q, 32'h0000_0000);
        @(posedge clk);
        #1 check_eq("rst_held_q", q, 32'h0000_0000);
        @(negedge clk);
        resetn = 1'b1;
        last_q = '0;
        repeat (16) @(posedge clk);
        #1 check_eq("rst_no_update", q, 32'h0000_0000);
        run_op("rst_restart",  32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
